// File: rtl/pipe_stall_sequencer_pkg.sv
// Shared pipeline-control definitions: stage indices, default depth,
// sequencer state type and the common RUN-style transition rule.
package pipe_ctrl_pkg;

    localparam int unsigned NUM_STAGES_DEFAULT = 5;

    localparam int unsigned STG_IF  = 0;
    localparam int unsigned STG_ID  = 1;
    localparam int unsigned STG_EX  = 2;
    localparam int unsigned STG_MEM = 3;
    localparam int unsigned STG_WB  = 4;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        I_WAIT  = 2'd1,
        D_WAIT  = 2'd2,
        RELEASE = 2'd3
    } seq_state_e;

    // The older instruction (D-side) wins when both caches miss together.
    function automatic seq_state_e run_next(input logic dmiss, input logic imiss);
        if (dmiss) begin
            return D_WAIT;
        end else if (imiss) begin
            return I_WAIT;
        end
        return RUN;
    endfunction

endpackage

// File: rtl/pipe_stall_sequencer_if.sv
// Hazard-unit / cache handshake bundle seen by the stall sequencer.
interface pipe_stall_sequencer_if #(
    parameter int unsigned NUM_STAGES = 5,
    parameter int unsigned CNT_W      = 32
);
    logic [NUM_STAGES-1:0] hz_stall_i;
    logic [NUM_STAGES-1:0] hz_flush_i;
    logic                  imiss_i;
    logic                  iready_i;
    logic                  dmiss_i;
    logic                  dready_i;
    logic [NUM_STAGES-1:0] en_o;
    logic [NUM_STAGES-1:0] clr_o;
    logic                  frozen_o;
    logic [CNT_W-1:0]      ist_cnt_o;
    logic [CNT_W-1:0]      dst_cnt_o;

    modport master (
        output hz_stall_i, hz_flush_i, imiss_i, iready_i, dmiss_i, dready_i,
        input  en_o, clr_o, frozen_o, ist_cnt_o, dst_cnt_o
    );

    modport slave (
        input  hz_stall_i, hz_flush_i, imiss_i, iready_i, dmiss_i, dready_i,
        output en_o, clr_o, frozen_o, ist_cnt_o, dst_cnt_o
    );
endinterface

// File: rtl/pipe_stall_sequencer_sat_cycle_cnt.sv
// Saturating cycle counter: counts enabled cycles, sticks at all-ones.
module sat_cycle_cnt #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    output logic [CNT_W-1:0] cnt_o
);
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (en_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;
endmodule

// File: rtl/pipe_stall_sequencer.sv
// Turns hazard stall/flush vectors and cache miss handshakes into per-stage
// enable/clear strobes. Optional stall counters: PIPE_STALL_PERF_CNT_EN.
module pipe_stall_sequencer
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned NUM_STAGES = NUM_STAGES_DEFAULT,
    parameter int unsigned CNT_W      = 32
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    pipe_stall_sequencer_if.slave  bus
);
    seq_state_e            state_q, state_d;
    logic [NUM_STAGES-1:0] pend_flush_q, pend_flush_d;
    logic                  imiss_pend_q, imiss_pend_d;
    logic                  iready_seen_q, iready_seen_d;

    logic [NUM_STAGES-1:0] en;
    logic [NUM_STAGES-1:0] clr;
    logic                  frozen;
    logic [NUM_STAGES-1:0] run_en;

    always_comb begin
        state_d       = state_q;
        pend_flush_d  = pend_flush_q;
        imiss_pend_d  = imiss_pend_q;
        iready_seen_d = iready_seen_q;
        run_en        = ~bus.hz_stall_i | bus.hz_flush_i;
        en            = '1;
        clr           = '0;
        frozen        = 1'b0;

        case (state_q)
            RUN: begin
                en      = run_en;
                clr     = bus.hz_flush_i;
                state_d = run_next(bus.dmiss_i, bus.imiss_i);
            end
            I_WAIT: begin
                en          = run_en;
                clr         = bus.hz_flush_i;
                en[STG_IF]  = 1'b0;
                clr[STG_IF] = 1'b0;
                en[STG_ID]  = 1'b1;
                clr[STG_ID] = 1'b1;
                pend_flush_d[STG_IF] = pend_flush_q[STG_IF] | bus.hz_flush_i[STG_IF];
                pend_flush_d[STG_ID] = pend_flush_q[STG_ID] | bus.hz_flush_i[STG_ID];
                // A refill completing under a D-miss is remembered so the
                // I-miss is not waited on again after the D-side releases.
                if (bus.dmiss_i) begin
                    state_d      = D_WAIT;
                    imiss_pend_d = 1'b1;
                    if (bus.iready_i) begin
                        iready_seen_d = 1'b1;
                    end
                end else if (bus.iready_i || iready_seen_q) begin
                    state_d       = RELEASE;
                    iready_seen_d = 1'b0;
                end
            end
            D_WAIT: begin
                en           = '0;
                clr          = '0;
                frozen       = 1'b1;
                pend_flush_d = pend_flush_q | bus.hz_flush_i;
                if (bus.iready_i && imiss_pend_q) begin
                    iready_seen_d = 1'b1;
                end
                if (bus.dready_i) begin
                    if (imiss_pend_q) begin
                        state_d      = I_WAIT;
                        imiss_pend_d = 1'b0;
                    end else begin
                        state_d = RELEASE;
                    end
                end
            end
            RELEASE: begin
                en           = ~bus.hz_stall_i | bus.hz_flush_i | pend_flush_q;
                clr          = bus.hz_flush_i | pend_flush_q;
                pend_flush_d = '0;
                state_d      = run_next(bus.dmiss_i, bus.imiss_i);
            end
            default: begin
                state_d = RUN;
            end
        endcase

        if (rst_i) begin
            en     = '1;
            clr    = '1;
            frozen = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= RUN;
            pend_flush_q  <= '0;
            imiss_pend_q  <= 1'b0;
            iready_seen_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            pend_flush_q  <= pend_flush_d;
            imiss_pend_q  <= imiss_pend_d;
            iready_seen_q <= iready_seen_d;
        end
    end

    assign bus.en_o     = en;
    assign bus.clr_o    = clr;
    assign bus.frozen_o = frozen;

`ifdef PIPE_STALL_PERF_CNT_EN
    logic [CNT_W-1:0] ist_cnt;
    logic [CNT_W-1:0] dst_cnt;

    sat_cycle_cnt #(.CNT_W(CNT_W)) u_ist_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .en_i  (state_q == I_WAIT),
        .cnt_o (ist_cnt)
    );

    sat_cycle_cnt #(.CNT_W(CNT_W)) u_dst_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .en_i  (state_q == D_WAIT),
        .cnt_o (dst_cnt)
    );

    assign bus.ist_cnt_o = ist_cnt;
    assign bus.dst_cnt_o = dst_cnt;
`else
    assign bus.ist_cnt_o = {CNT_W{1'b0}};
    assign bus.dst_cnt_o = {CNT_W{1'b0}};
`endif
endmodule
